// File: rtl/car_drive_model.sv
// Grid drive model: turns rWheel/lWheel commands into a pose (carX, carY, heading).
// Latency: the first motion lands TICKS+1 edges after a steady command appears, then every TICKS edges.
// Backpressure: none. A changed command restarts counting and discards any partial step or turn.
module car_drive_model #(
   parameter int          STEP_TICKS = 4,
   parameter int          TURN_TICKS = 8,
   parameter logic [31:0] STEP_SIZE  = 32'd1,
   parameter logic [31:0] INIT_X     = 32'd0,
   parameter logic [31:0] INIT_Y     = 32'd0,
   parameter logic [1:0]  INIT_HEAD  = 2'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  rWheel,
   input  logic [1:0]  lWheel,
   input  logic        load,
   input  logic [31:0] load_x,
   input  logic [31:0] load_y,
   input  logic [1:0]  load_head,
   output logic [31:0] carX,
   output logic [31:0] carY,
   output logic [1:0]  heading,
   output logic        moving,
   output logic        pos_upd,
   output logic        at_edge
);

   typedef enum logic [2:0] {IDLE, FWD, REV, TURN_L, TURN_R} mode_t;

   localparam int MAX_TICKS = (STEP_TICKS > TURN_TICKS) ? STEP_TICKS : TURN_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);

   mode_t            mode, modeNxt, cmd;
   logic [CNT_W-1:0] cnt, cntNxt, lastTick;
   logic [31:0]      xNxt, yNxt, coord, stepVal;
   logic [1:0]       headNxt, moveDir;
   logic             updNxt, edgeNxt, clip;
   logic [32:0]      sum33, diff33;

   // Decode the wheel pair into the requested motion mode
   always_comb begin
      cmd = IDLE;
      case ({rWheel, lWheel})
         4'b0101: cmd = FWD;
         4'b1010: cmd = REV;
         4'b0100: cmd = TURN_L;
         4'b0001: cmd = TURN_R;
         default: cmd = IDLE;
      endcase
   end

   // Saturating one-step move along the travel direction (reverse travels opposite to heading)
   always_comb begin
      moveDir = (mode == REV) ? heading + 2'd2 : heading;
      coord   = moveDir[0] ? carX : carY;
      sum33   = {1'b0, coord} + {1'b0, STEP_SIZE};
      diff33  = {1'b0, coord} - {1'b0, STEP_SIZE};
      if (moveDir[1]) begin
         clip    = diff33[32];
         stepVal = diff33[32] ? 32'd0 : diff33[31:0];
      end else begin
         clip    = sum33[32];
         stepVal = sum33[32] ? 32'hFFFF_FFFF : sum33[31:0];
      end
   end

   // Next-state: load, mode change, tick counting and motion application
   always_comb begin
      modeNxt  = mode;
      cntNxt   = cnt;
      xNxt     = carX;
      yNxt     = carY;
      headNxt  = heading;
      updNxt   = 1'b0;
      edgeNxt  = 1'b0;
      lastTick = (mode == FWD || mode == REV) ? STEP_LAST : TURN_LAST;
      if (load) begin
         xNxt    = load_x;
         yNxt    = load_y;
         headNxt = load_head;
         modeNxt = IDLE;
         cntNxt  = '0;
      end else if (cmd != mode) begin
         modeNxt = cmd;
         cntNxt  = '0;
      end else if (mode == IDLE) begin
         cntNxt = cnt;
      end else if (cnt == lastTick) begin
         cntNxt = '0;
         case (mode)
            TURN_R: begin
               headNxt = heading + 2'd1;
               updNxt  = 1'b1;
            end
            TURN_L: begin
               headNxt = heading - 2'd1;
               updNxt  = 1'b1;
            end
            default: begin
               if (moveDir[0]) xNxt = stepVal;
               else            yNxt = stepVal;
               updNxt  = (stepVal != coord);
               edgeNxt = clip;
            end
         endcase
      end else begin
         cntNxt = cnt + 1'b1;
      end
   end

   // State and registered outputs; reset drops any partial step or turn
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode    <= IDLE;
         cnt     <= '0;
         carX    <= INIT_X;
         carY    <= INIT_Y;
         heading <= INIT_HEAD;
         pos_upd <= 1'b0;
         at_edge <= 1'b0;
      end else begin
         mode    <= modeNxt;
         cnt     <= cntNxt;
         carX    <= xNxt;
         carY    <= yNxt;
         heading <= headNxt;
         pos_upd <= updNxt;
         at_edge <= edgeNxt;
      end
   end

   // moving depends only on the mode register
   always_comb begin
      moving = (mode != IDLE);
   end

endmodule

// File: tb/tb_car_drive_model.sv
// Scoreboard bench for car_drive_model (STEP_SIZE=4 so that the clamp case is reachable).
// Stimulus pushes the expected pose and the edge on which each pos_upd/at_edge pulse is due.
// A negedge monitor pops one entry per pulse and compares it.
module tb_car_drive_model;

   logic        clk;
   logic        reset;
   logic [1:0]  rWheel, lWheel;
   logic        load;
   logic [31:0] load_x, load_y;
   logic [1:0]  load_head;
   logic [31:0] carX, carY;
   logic [1:0]  heading;
   logic        moving, pos_upd, at_edge;

   car_drive_model #(
      .STEP_TICKS(4), .TURN_TICKS(8), .STEP_SIZE(32'd4),
      .INIT_X(32'd0), .INIT_Y(32'd0), .INIT_HEAD(2'd1)
   ) dut (
      .clk(clk), .reset(reset), .rWheel(rWheel), .lWheel(lWheel),
      .load(load), .load_x(load_x), .load_y(load_y), .load_head(load_head),
      .carX(carX), .carY(carY), .heading(heading),
      .moving(moving), .pos_upd(pos_upd), .at_edge(at_edge)
   );

   typedef struct {
      int          edgeN;
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  h;
      logic        pu;
      logic        ae;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   edgeCnt = 0;
   int   checks  = 0;
   int   passes  = 0;
   int   base;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input int edgeN, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] h, input logic pu, input logic ae);
      exp_t n;
      n.edgeN = edgeN; n.x = x; n.y = y; n.h = h; n.pu = pu; n.ae = ae;
      sb.push_back(n);
   endtask

   task automatic setCmd(input logic [1:0] r, input logic [1:0] l);
      rWheel = r;
      lWheel = l;
   endtask

   task automatic doLoad(input logic [31:0] x, input logic [31:0] y, input logic [1:0] h);
      load = 1'b1; load_x = x; load_y = y; load_head = h;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Monitor: every pulse must match the next scoreboard entry
   always @(negedge clk) begin
      if (!reset && (pos_upd || at_edge)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 64'(edgeCnt), 64'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("event_edge", 64'(edgeCnt), 64'(e.edgeN));
            check("event_carX", 64'(carX), 64'(e.x));
            check("event_carY", 64'(carY), 64'(e.y));
            check("event_heading", 64'(heading), 64'(e.h));
            check("event_pos_upd", 64'(pos_upd), 64'(e.pu));
            check("event_at_edge", 64'(at_edge), 64'(e.ae));
         end
      end
   end

   initial begin
      reset = 1'b1; load = 1'b0; load_x = '0; load_y = '0; load_head = '0;
      setCmd(2'b00, 2'b00);
      #3;
      check("reset_carX", 64'(carX), 64'd0);
      check("reset_carY", 64'(carY), 64'd0);
      check("reset_heading", 64'(heading), 64'd1);
      check("reset_moving", 64'(moving), 64'd0);
      check("reset_pos_upd", 64'(pos_upd), 64'd0);
      check("reset_at_edge", 64'(at_edge), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Forward along +X: steps at edges 5, 9, 13
      setCmd(2'b01, 2'b01); base = edgeCnt;
      push(base + 5, 32'd4, 32'd0, 2'd1, 1'b1, 1'b0);
      push(base + 9, 32'd8, 32'd0, 2'd1, 1'b1, 1'b0);
      push(base + 13, 32'd12, 32'd0, 2'd1, 1'b1, 1'b0);
      repeat (13) @(negedge clk);
      check("fwd_moving", 64'(moving), 64'd1);
      check("fwd_carX", 64'(carX), 64'd12);
      setCmd(2'b00, 2'b00);
      @(negedge clk);
      check("stop_moving", 64'(moving), 64'd0);
      check("fwd_sb_empty", 64'(sb.size()), 64'd0);

      // Pivot right 1->2, then left 2->1
      setCmd(2'b00, 2'b01); base = edgeCnt;
      push(base + 9, 32'd12, 32'd0, 2'd2, 1'b1, 1'b0);
      repeat (9) @(negedge clk);
      setCmd(2'b01, 2'b00); base = edgeCnt;
      push(base + 9, 32'd12, 32'd0, 2'd1, 1'b1, 1'b0);
      repeat (9) @(negedge clk);
      setCmd(2'b00, 2'b00);
      @(negedge clk);
      check("turn_heading", 64'(heading), 64'd1);

      // Left pivot wraps heading 0 -> 3
      doLoad(32'd12, 32'd0, 2'd0);
      check("load_heading0", 64'(heading), 64'd0);
      setCmd(2'b01, 2'b00); base = edgeCnt;
      push(base + 9, 32'd12, 32'd0, 2'd3, 1'b1, 1'b0);
      repeat (9) @(negedge clk);

      // Interrupted right pivot is discarded
      setCmd(2'b00, 2'b01);
      repeat (5) @(negedge clk);
      setCmd(2'b00, 2'b00);
      @(negedge clk);
      check("abort_moving", 64'(moving), 64'd0);
      repeat (3) @(negedge clk);
      check("abort_heading", 64'(heading), 64'd3);
      check("turns_sb_empty", 64'(sb.size()), 64'd0);

      // Push on the X=0 wall facing -X: at_edge only
      doLoad(32'd0, 32'd0, 2'd3);
      setCmd(2'b01, 2'b01); base = edgeCnt;
      push(base + 5, 32'd0, 32'd0, 2'd3, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      setCmd(2'b00, 2'b00);
      check("wall_carX", 64'(carX), 64'd0);

      // Near the top: first step clamps with change, second repeats at_edge only
      doLoad(32'hFFFF_FFFE, 32'd0, 2'd1);
      setCmd(2'b01, 2'b01); base = edgeCnt;
      push(base + 5, 32'hFFFF_FFFF, 32'd0, 2'd1, 1'b1, 1'b1);
      push(base + 9, 32'hFFFF_FFFF, 32'd0, 2'd1, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      setCmd(2'b00, 2'b00);

      // Reverse while facing +Y moves -Y
      doLoad(32'd100, 32'd50, 2'd0);
      setCmd(2'b10, 2'b10); base = edgeCnt;
      push(base + 5, 32'd100, 32'd46, 2'd0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      setCmd(2'b00, 2'b00);
      @(negedge clk);
      check("edge_sb_empty", 64'(sb.size()), 64'd0);

      // Load wins over a simultaneous forward command
      setCmd(2'b01, 2'b01);
      load = 1'b1; load_x = 32'd20; load_y = 32'd30; load_head = 2'd1;
      @(negedge clk);
      check("load_carX", 64'(carX), 64'd20);
      check("load_moving", 64'(moving), 64'd0);
      load = 1'b0; base = edgeCnt;
      push(base + 5, 32'd24, 32'd30, 2'd1, 1'b1, 1'b0);
      repeat (7) @(negedge clk);
      check("pre_reset_carX", 64'(carX), 64'd24);

      // Asynchronous reset mid-step
      reset = 1'b1;
      #1;
      check("areset_carX", 64'(carX), 64'd0);
      check("areset_carY", 64'(carY), 64'd0);
      check("areset_heading", 64'(heading), 64'd1);
      check("areset_moving", 64'(moving), 64'd0);
      setCmd(2'b00, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("final_carX", 64'(carX), 64'd0);
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
